// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a single-outstanding
// req/ack port and buffers {pc, word} pairs in a prefetch FIFO for decode.
module instruction_fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             imem_req,
  output logic [31:0]                      imem_addr,
  input  logic                             imem_ack,
  input  logic [31:0]                      imem_rdata,
  input  logic                             redirect_valid,
  input  logic [31:0]                      redirect_pc,
  output logic                             inst_valid,
  input  logic                             inst_ready,
  output logic [31:0]                      inst,
  output logic [31:0]                      inst_pc,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  // state   | meaning
  // IDLE    | no request outstanding (FIFO full or just out of reset)
  // REQ     | request for fetch_pc outstanding; data is kept on ack
  // DISCARD | request for fetch_pc outstanding; data is dropped, then jump to target_pc
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [31:0]     target_pc;
  logic [31:0]     fifo_word [FIFO_DEPTH];
  logic [31:0]     fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after;
  logic [31:0]     redirect_aligned;
  logic            push;
  logic            pop;

  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  // A redirect cycle flushes, so neither push nor pop takes effect then.
  assign push        = (state == REQ) && imem_ack && !redirect_valid;
  assign pop         = inst_valid && inst_ready && !redirect_valid;
  assign count_after = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      fetch_pc  <= RESET_PC & 32'hFFFF_FFFC;
      target_pc <= RESET_PC & 32'hFFFF_FFFC;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            state    <= REQ;
            imem_req <= 1'b1;
          end else if (count < FULL) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            if (imem_ack) begin
              fetch_pc <= redirect_aligned;
            end else begin
              target_pc <= redirect_aligned;
              state     <= DISCARD;
            end
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (count_after >= FULL) begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DISCARD: begin
          // Address stays on the stale request until memory answers it.
          if (imem_ack) begin
            fetch_pc <= redirect_valid ? redirect_aligned : target_pc;
            state    <= REQ;
          end else if (redirect_valid) begin
            target_pc <= redirect_aligned;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_word[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]   <= fetch_pc;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_after;
    end
  end

  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? fifo_word[rd_ptr] : 32'd0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : 32'd0;
  assign fifo_count = count;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the single-cycle datapath: owns the program counter and fetches 32-bit instruction words from instruction memory over a req/ack interface.
- Buffers fetched words with their PCs in a small prefetch FIFO and presents them to decode/execute over a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage; a redirect flushes the FIFO and discards any in-flight fetch.

Parameters:
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >= 2
- RESET_PC, 32'h0000_0000, byte address fetched first after reset

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- imem_req  output  1  fetch request, registered
- imem_addr  output  32  byte address of the request; bits [1:0] always 0
- imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req=0
- imem_rdata  input  32  instruction word, valid with imem_ack
- redirect_valid  input  1  execute stage requests a PC change
- redirect_pc  input  32  new byte PC; bits [1:0] ignored and treated as 00
- inst_valid  output  1  FIFO head valid (FIFO non-empty)
- inst_ready  input  1  consumer accepts head
- inst  output  32  head instruction word; 0 when empty
- inst_pc  output  32  byte PC of the head word; 0 when empty
- fifo_count  output  $clog2(FIFO_DEPTH+1)  occupied entries

Behaviour:
- Reset (synchronous): state=IDLE, fetch_pc=RESET_PC, FIFO count=0. Outputs: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fifo_count=0. A reset in mid-fetch abandons the fetch; an ack arriving after reset while imem_req=0 is ignored.
- PC is a byte address and advances by +4 per accepted word. Wrap-around goes from 32'hFFFF_FFFC to 0.
- Only one request may be outstanding. imem_req and imem_addr are held stable until imem_ack. Zero-wait memory (ack in the same cycle as req) is supported.
- IDLE:
  - redirect: fetch_pc <= redirect_pc; go to REQ.
  - otherwise, if count < FIFO_DEPTH: go to REQ.
- REQ: imem_req=1, imem_addr=fetch_pc.
  - ack without redirect: push {fetch_pc, imem_rdata} and set fetch_pc += 4. Stay in REQ if the post-cycle count < FIFO_DEPTH, otherwise go to IDLE.
  - redirect with ack: drop the data, fetch_pc <= redirect_pc, stay in REQ (new address next cycle).
  - redirect without ack: latch redirect_pc as the target and go to DISCARD.
- DISCARD: imem_req=1, imem_addr=old address (unchanged).
  - ack: drop the data, fetch_pc <= target, go to REQ.
  - further redirect: overwrite the target. If it coincides with an ack, the new target is used.
- FIFO:
  - pop when inst_valid && inst_ready.
  - simultaneous push and pop: count unchanged, head advances.
  - no push ever occurs while full; this is guaranteed by the REQ entry/stay rule.
- Redirect priority: flush over pop and push. In a redirect cycle, count <= 0 and the head is not consumed; inst_valid=0 in the following cycle.
- Latency, zero-wait memory, inst_ready=1:
  - imem_req rises 1 cycle after rst deasserts.
  - first inst_valid follows 1 cycle later.
  - sustained throughput is one instruction per cycle.
- Latency after redirect with zero-wait memory: the new PC's instruction is valid 2 cycles after the redirect cycle.

Test Plan:
- Reset, zero-wait memory with rdata=addr^32'hA5A5_0000, inst_ready=1 -> inst_pc sequence 0,4,8,12,16 on consecutive cycles; first inst_valid 2 cycles after reset release; inst matches the formula.
- inst_ready=0, zero-wait memory -> fifo_count reaches 4 (pcs 0,4,8,12 buffered); imem_req drops, no request for 0x10. Raising inst_ready -> pops 0,4,8,12, then a request for 0x10 resumes.
- Ack delayed 3 cycles, redirect_pc=0x40 asserted 1 cycle after req for 0x8 -> imem_addr stays 0x8 until ack; that data is never presented; FIFO flushed; next inst_pc=0x40.
- Redirect_pc=0x83 in the same cycle as ack for 0x10 -> data for 0x10 dropped; next imem_addr=0x80; next inst_pc=0x80.
- fifo_count=2, ack and pop in the same cycle -> fifo_count stays 2; head advances by 4.
- rst asserted while a request is outstanding and the FIFO holds 3 entries -> next cycle imem_req=0, fifo_count=0, inst_valid=0, imem_addr=RESET_PC; a late ack is ignored; fetch restarts at RESET_PC.
